// File: rtl/systolic_array_pkg.sv
// -----------------------------------------------------------------------------
// systolic_array_pkg
// Shared types for the systolic array and the blocks around it.
//   word_t : one data lane, a raw IEEE-754 single-precision bit pattern.
//            The feeder only moves these words and never interprets them.
// -----------------------------------------------------------------------------
package systolic_array_pkg;

    typedef logic [31:0] word_t;

endpackage

// File: rtl/systolic_feeder_if.sv
// -----------------------------------------------------------------------------
// systolic_feeder_if
// Upstream k-slice stream into systolic_feeder.
//   in_valid : a k-slice (X column-vector plus W row-vector) is presented
//   in_x     : X values, lane i = array row i
//   in_w     : W values, lane j = array column j
//   in_last  : final k-slice of the tile (meaningful only on an accepted beat)
//   in_ready : the feeder takes the beat this cycle
// master = upstream producer, slave = systolic_feeder.
// -----------------------------------------------------------------------------
interface systolic_feeder_if
    import systolic_array_pkg::*;
#(
    parameter int N = 4
) ();

    logic            in_valid;
    word_t [N-1:0]   in_x;
    word_t [N-1:0]   in_w;
    logic            in_last;
    logic            in_ready;

    modport master (
        output in_valid,
        output in_x,
        output in_w,
        output in_last,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_x,
        input  in_w,
        input  in_last,
        output in_ready
    );

endinterface

// File: rtl/systolic_feeder.sv
// -----------------------------------------------------------------------------
// systolic_feeder
// Accepts one k-slice per beat and pushes it into an N x N systolic array with
// the diagonal skew the array expects: lane k is delayed by k+1 advances.
// After the last slice of a tile it pushes N all-zero rows to drain the array,
// then pulses done for one cycle.
//
// Ports
//   clk       : clock, rising edge
//   n_rst     : asynchronous active-low reset
//   up        : upstream k-slice stream (systolic_feeder_if.slave)
//   stall     : array cannot advance; freezes all feeder state
//   start     : high while a tile is being fed (to array start)
//   x_out     : skewed X stream (to array x_in)
//   w_out     : skewed W stream (to array w_in)
//   done      : one-cycle pulse when the tile has fully drained
//   row_count : accepted k-slices in the current tile (saturating)
// -----------------------------------------------------------------------------
module systolic_feeder
    import systolic_array_pkg::*;
#(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           n_rst,
    systolic_feeder_if.slave up,
    input  logic           stall,
    output logic           start,
    output word_t [N-1:0]  x_out,
    output word_t [N-1:0]  w_out,
    output logic           done,
    output logic [15:0]    row_count
);

    localparam int FCW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [FCW-1:0]   flush_cnt_q;
    logic [FCW-1:0]   flush_cnt_d;
    logic [15:0]      row_count_q;
    logic [15:0]      row_count_d;
    logic             done_q;
    logic             done_d;

    logic             in_ready_s;
    logic             accept_s;
    logic             adv_s;
    logic             start_s;
    word_t [N-1:0]    push_x_s;
    word_t [N-1:0]    push_w_s;

    // Handshake, advance qualification and next-state for the tile sequencer.
    always_comb begin
        in_ready_s  = 1'b0;
        adv_s       = 1'b0;
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        row_count_d = row_count_q;
        start_s     = 1'b0;

        case (state_q)
            ST_IDLE:  in_ready_s = ~stall;
            ST_LOAD:  in_ready_s = ~stall;
            ST_FLUSH: in_ready_s = 1'b0;
            ST_DONE:  in_ready_s = 1'b0;
            default:  in_ready_s = 1'b0;
        endcase

        accept_s = up.in_valid & in_ready_s;

        // IDLE only advances when it takes a beat; LOAD pushes bubbles on gaps.
        case (state_q)
            ST_IDLE:  adv_s = accept_s;
            ST_LOAD:  adv_s = ~stall;
            ST_FLUSH: adv_s = ~stall;
            ST_DONE:  adv_s = 1'b0;
            default:  adv_s = 1'b0;
        endcase

        if (accept_s && (row_count_q != 16'hFFFF)) begin
            row_count_d = row_count_q + 16'd1;
        end else begin
            row_count_d = row_count_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d = up.in_last ? ST_FLUSH : ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (accept_s && up.in_last) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_FLUSH: begin
                if (adv_s) begin
                    if (flush_cnt_q == FCW'(N - 1)) begin
                        flush_cnt_d = {FCW{1'b0}};
                        state_d     = ST_DONE;
                    end else begin
                        flush_cnt_d = flush_cnt_q + FCW'(1);
                        state_d     = ST_FLUSH;
                    end
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_DONE: begin
                // Leaves after one cycle even under stall; the count clears here.
                state_d     = ST_IDLE;
                row_count_d = 16'd0;
            end
            default: begin
                state_d     = ST_IDLE;
                flush_cnt_d = {FCW{1'b0}};
            end
        endcase

        done_d = (state_d == ST_DONE);

        // start covers the accepting IDLE cycle so the array sees it with beat 1.
        case (state_q)
            ST_IDLE:  start_s = accept_s;
            ST_LOAD:  start_s = 1'b1;
            ST_FLUSH: start_s = 1'b1;
            ST_DONE:  start_s = 1'b0;
            default:  start_s = 1'b0;
        endcase

        if (accept_s) begin
            push_x_s = up.in_x;
            push_w_s = up.in_w;
        end else begin
            push_x_s = {N{32'h0000_0000}};
            push_w_s = {N{32'h0000_0000}};
        end
    end

    // Sequencer state, flush counter, row counter and done pulse registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= ST_IDLE;
            flush_cnt_q <= {FCW{1'b0}};
            row_count_q <= 16'd0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            row_count_q <= row_count_d;
            done_q      <= done_d;
        end
    end

    // Per-lane skew: a chain of k+1 registers, the last one being the output.
    for (genvar k = 0; k < N; k++) begin : g_lane
        word_t x_pipe_q [0:k];
        word_t x_pipe_d [0:k];
        word_t w_pipe_q [0:k];
        word_t w_pipe_d [0:k];

        // Shift the lane chain by one on every advance, hold otherwise.
        always_comb begin
            if (adv_s) begin
                x_pipe_d[0] = push_x_s[k];
                w_pipe_d[0] = push_w_s[k];
            end else begin
                x_pipe_d[0] = x_pipe_q[0];
                w_pipe_d[0] = w_pipe_q[0];
            end
            for (int i = 1; i <= k; i++) begin
                if (adv_s) begin
                    x_pipe_d[i] = x_pipe_q[i-1];
                    w_pipe_d[i] = w_pipe_q[i-1];
                end else begin
                    x_pipe_d[i] = x_pipe_q[i];
                    w_pipe_d[i] = w_pipe_q[i];
                end
            end
        end

        // Lane chain registers; reset drops any in-flight data.
        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                for (int i = 0; i <= k; i++) begin
                    x_pipe_q[i] <= 32'h0000_0000;
                    w_pipe_q[i] <= 32'h0000_0000;
                end
            end else begin
                for (int i = 0; i <= k; i++) begin
                    x_pipe_q[i] <= x_pipe_d[i];
                    w_pipe_q[i] <= w_pipe_d[i];
                end
            end
        end

        assign x_out[k] = x_pipe_q[k];
        assign w_out[k] = w_pipe_q[k];
    end

    assign up.in_ready = in_ready_s;
    assign start       = start_s;
    assign done        = done_q;
    assign row_count   = row_count_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// -----------------------------------------------------------------------------
// tb_systolic_feeder
// Random and directed stimulus against a behavioural model: the model keeps the
// history of pushed rows and derives each lane's output as "the row pushed
// k+1 advances ago", plus a tile-phase tracker for handshake and done timing.
// -----------------------------------------------------------------------------
module tb_systolic_feeder;
    import systolic_array_pkg::*;

    localparam int N = 4;

    typedef logic [31:0] row_t [N];
    typedef enum int {P_IDLE, P_LOAD, P_FLUSH, P_DONE} phase_t;

    logic          clk;
    logic          n_rst;
    logic          stall;
    logic          start;
    logic          done;
    logic [15:0]   row_count;
    word_t [N-1:0] x_out;
    word_t [N-1:0] w_out;

    systolic_feeder_if #(.N(N)) bif ();

    systolic_feeder #(.N(N)) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .up        (bif),
        .stall     (stall),
        .start     (start),
        .x_out     (x_out),
        .w_out     (w_out),
        .done      (done),
        .row_count (row_count)
    );

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    // model state
    phase_t m_phase;
    int     m_flush;
    int     m_rows;
    bit     m_acc;
    row_t   hx[$];
    row_t   hw[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit m_ready();
        return !stall && (m_phase == P_IDLE || m_phase == P_LOAD);
    endfunction

    function automatic logic [31:0] m_lane(input bit is_w, input int k);
        if (hx.size() > k) begin
            return is_w ? hw[hw.size()-1-k][k] : hx[hx.size()-1-k][k];
        end
        return 32'h0;
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE;
        m_flush = 0;
        m_rows  = 0;
        m_acc   = 1'b0;
        hx.delete();
        hw.delete();
    endtask

    task automatic model_step();
        bit   acc;
        bit   adv;
        row_t rx;
        row_t rw;
        acc = bif.in_valid && m_ready();
        adv = acc || (!stall && (m_phase == P_LOAD || m_phase == P_FLUSH));
        m_acc = acc;
        if (adv) begin
            for (int k = 0; k < N; k++) begin
                rx[k] = acc ? bif.in_x[k] : 32'h0;
                rw[k] = acc ? bif.in_w[k] : 32'h0;
            end
            hx.push_back(rx);
            hw.push_back(rw);
            if (hx.size() > N) begin
                hx.delete(0);
                hw.delete(0);
            end
        end
        if (acc && m_rows < 65535) m_rows++;
        case (m_phase)
            P_IDLE:  if (acc) m_phase = bif.in_last ? P_FLUSH : P_LOAD;
            P_LOAD:  if (acc && bif.in_last) m_phase = P_FLUSH;
            P_FLUSH: if (adv) begin
                m_flush++;
                if (m_flush == N) begin
                    m_flush = 0;
                    m_phase = P_DONE;
                end
            end
            P_DONE: begin
                m_phase = P_IDLE;
                m_rows  = 0;
            end
            default: m_phase = P_IDLE;
        endcase
    endtask

    task automatic compare();
        bit rdy;
        bit acc;
        rdy = m_ready();
        acc = bif.in_valid && rdy;
        chk("in_ready", {31'b0, bif.in_ready}, {31'b0, rdy});
        chk("start", {31'b0, start},
            {31'b0, (m_phase == P_LOAD || m_phase == P_FLUSH || (m_phase == P_IDLE && acc))});
        chk("done", {31'b0, done}, {31'b0, m_phase == P_DONE});
        chk("row_count", {16'b0, row_count}, m_rows);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("x_out[%0d]", k), x_out[k], m_lane(1'b0, k));
            chk($sformatf("w_out[%0d]", k), w_out[k], m_lane(1'b1, k));
        end
    endtask

    // model advance on every rising edge out of reset
    initial begin
        forever begin
            @(posedge clk);
            if (n_rst) model_step();
        end
    end

    // single compare process, sampled mid low phase
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (cmp_en) compare();
        end
    end

    function automatic word_t fval(input int n);
        case (n)
            1:  return 32'h3F80_0000;
            2:  return 32'h4000_0000;
            3:  return 32'h4040_0000;
            4:  return 32'h4080_0000;
            6:  return 32'h40C0_0000;
            8:  return 32'h4100_0000;
            9:  return 32'h4110_0000;
            12: return 32'h4140_0000;
            16: return 32'h4180_0000;
            default: return 32'h0;
        endcase
    endfunction

    task automatic drive_idle();
        bif.in_valid = 1'b0;
        bif.in_last  = 1'b0;
        stall        = 1'b0;
    endtask

    task automatic drive_mult(input int b, input bit last);
        bif.in_valid = 1'b1;
        bif.in_last  = last;
        stall        = 1'b0;
        for (int k = 0; k < N; k++) begin
            bif.in_x[k] = fval((k + 1) * b);
            bif.in_w[k] = fval((k + 1) * b);
        end
    endtask

    task automatic drive_tag(input logic [31:0] base, input bit last);
        bif.in_valid = 1'b1;
        bif.in_last  = last;
        stall        = 1'b0;
        for (int k = 0; k < N; k++) begin
            bif.in_x[k] = base + k;
            bif.in_w[k] = (base ^ 32'h0F00_0000) + k;
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s x_out[%0d]", tag, k), x_out[k], 32'h0);
            chk($sformatf("%s w_out[%0d]", tag, k), w_out[k], 32'h0);
        end
        chk({tag, " done"}, {31'b0, done}, 32'h0);
        chk({tag, " start"}, {31'b0, start}, 32'h0);
        chk({tag, " row_count"}, {16'b0, row_count}, 32'h0);
    endtask

    bit pend;

    initial begin
        n_rst        = 1'b0;
        stall        = 1'b0;
        bif.in_valid = 1'b0;
        bif.in_last  = 1'b0;
        bif.in_x     = '0;
        bif.in_w     = '0;
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        chk("reset in_ready", {31'b0, bif.in_ready}, 32'h1);
        n_rst  = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        // four-beat tile of scaled {1,2,3,4}
        for (int t = 0; t <= 10; t++) begin
            if (t < 4) drive_mult(t + 1, t == 3);
            else       drive_idle();
            #3;
            case (t)
                0: chk("seq1 start on accept", {31'b0, start}, 32'h1);
                1: begin
                    chk("seq1 x0 t1", x_out[0], 32'h3F80_0000);
                    chk("seq1 w0 t1", w_out[0], 32'h3F80_0000);
                    chk("seq1 x1 t1", x_out[1], 32'h0);
                end
                3: chk("seq1 x3 t3", x_out[3], 32'h0);
                4: begin
                    chk("seq1 x3 t4", x_out[3], 32'h4080_0000);
                    chk("seq1 w3 t4", w_out[3], 32'h4080_0000);
                    chk("seq1 x2 t4", x_out[2], 32'h40C0_0000);
                    chk("seq1 rows t4", {16'b0, row_count}, 32'd4);
                end
                7: chk("seq1 done t7", {31'b0, done}, 32'h0);
                8: begin
                    chk("seq1 done t8", {31'b0, done}, 32'h1);
                    chk("seq1 rows t8", {16'b0, row_count}, 32'd4);
                end
                9: begin
                    chk("seq1 done t9", {31'b0, done}, 32'h0);
                    chk("seq1 rows t9", {16'b0, row_count}, 32'd0);
                end
                default: ;
            endcase
            @(negedge clk);
        end

        // single beat carrying in_last straight from IDLE
        for (int t = 0; t <= 6; t++) begin
            if (t == 0) drive_tag(32'hA000_0000, 1'b1);
            else        drive_idle();
            #3;
            case (t)
                1: chk("seq2 start in flush", {31'b0, start}, 32'h1);
                3: chk("seq2 x3 t3", x_out[3], 32'h0);
                4: begin
                    chk("seq2 x3 t4", x_out[3], 32'hA000_0003);
                    chk("seq2 w3 t4", w_out[3], 32'hAF00_0003);
                    chk("seq2 done t4", {31'b0, done}, 32'h0);
                end
                5: chk("seq2 done t5", {31'b0, done}, 32'h1);
                6: chk("seq2 done t6", {31'b0, done}, 32'h0);
                default: ;
            endcase
            @(negedge clk);
        end

        // reset pulse while flushing a two-beat tile
        for (int t = 0; t <= 3; t++) begin
            if (t < 2) drive_tag(32'hC000_0010 + t * 32'h100, t == 1);
            else       drive_idle();
            if (t == 3) begin
                #3;
                chk("seq3 in flush before reset", {31'b0, bif.in_ready}, 32'h0);
                n_rst = 1'b0;
                model_reset();
                #1;
                check_all_zero("mid-flush reset");
            end
            @(negedge clk);
        end
        n_rst = 1'b1;
        repeat (6) @(negedge clk);

        // randomized traffic with stalls, gaps, stray in_last and rare resets
        pend = 1'b0;
        bif.in_valid = 1'b0;
        repeat (3000) begin
            if (m_acc) pend = 1'b0;
            if (!pend && $urandom_range(0, 9) < 7) begin
                pend = 1'b1;
                bif.in_last = ($urandom_range(0, 4) == 0);
                for (int k = 0; k < N; k++) begin
                    bif.in_x[k] = $urandom;
                    bif.in_w[k] = $urandom;
                end
            end
            bif.in_valid = pend;
            if (!pend) begin
                bif.in_last = $urandom_range(0, 1);
                for (int k = 0; k < N; k++) begin
                    bif.in_x[k] = $urandom;
                    bif.in_w[k] = $urandom;
                end
            end
            stall = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 399) == 0) begin
                #3;
                n_rst = 1'b0;
                model_reset();
                pend = 1'b0;
                bif.in_valid = 1'b0;
                @(negedge clk);
                n_rst = 1'b1;
            end else begin
                @(negedge clk);
            end
        end

        drive_idle();
        repeat (12) @(negedge clk);
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/systolic_feeder.md
SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

Interface
REQ-001 Parameter N, default 4: number of array lanes (rows and columns of the systolic_array it feeds); legal range 2..64.
REQ-002 Type word_t (32-bit IEEE-754 single, from systolic_array_pkg) is used for all data lanes; the block performs no arithmetic on data, only moves it.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 n_rst  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  an upstream row (one k-slice of X column-vector and W row-vector) is presented.
REQ-006 in_x  input  word_t[N]  X values for the current k-slice, lane i = row i.
REQ-007 in_w  input  word_t[N]  W values for the current k-slice, lane j = column j.
REQ-008 in_last  input  1  qualifies the final k-slice of a tile; sampled only on an accepted beat.
REQ-009 in_ready  output  1  the block accepts a beat this cycle.
REQ-010 stall  input  1  the array cannot advance this cycle; driven by systolic_array.
REQ-011 start  output  1  connects to systolic_array start.
REQ-012 x_out  output  word_t[N]  skewed X stream to array x_in.
REQ-013 w_out  output  word_t[N]  skewed W stream to array w_in.
REQ-014 done  output  1  one-cycle pulse: tile fully drained into the array.
REQ-015 row_count  output  16  accepted k-slices in the current tile.

Function
REQ-016 The state machine SHALL have states IDLE, LOAD, FLUSH, and DONE.
REQ-017 An "advance" SHALL occur on a cycle where stall=0 and the state is LOAD or FLUSH, or the state is IDLE with in_valid=1.
REQ-018 A beat SHALL be accepted when in_valid & in_ready; in_ready = !stall in IDLE and LOAD, and 0 in FLUSH and DONE.
REQ-019 On each advance, the pushed row SHALL be the accepted beat if present, else all-zero (bubble; contributes 0 to every product).
REQ-020 Skew: lane k of x_out/w_out SHALL present the lane-k value pushed k+1 advances earlier (lane 0 delay 1, lane N-1 delay N); k-deep shift register per lane plus output register.
REQ-021 When stall=1, all skew registers, outputs, row_count and state SHALL hold.
REQ-022 IDLE -> LOAD on an accepted beat with in_last=0; IDLE -> FLUSH on an accepted beat with in_last=1.
REQ-023 LOAD -> FLUSH on an accepted beat with in_last=1.
REQ-024 FLUSH SHALL push exactly N zero rows (advances), counted by a flush counter that freezes during stall, then -> DONE.
REQ-025 DONE SHALL assert done=1 for exactly one cycle, regardless of stall, and then -> IDLE.
REQ-026 start SHALL be 1 in LOAD and FLUSH, and on the IDLE cycle that accepts the first beat (combinational on acceptance); otherwise 0.
REQ-027 row_count SHALL increment on each accepted beat, saturate at 16'hFFFF, clear on entry to IDLE from DONE, and hold its value during DONE.
REQ-028 in_last outside an accepted beat SHALL be ignored; in_valid in FLUSH/DONE SHALL be back-pressured, with no data loss.

Reset
REQ-029 While n_rst=0 (asynchronous): state=IDLE; all skew registers, x_out, w_out=0; start=0; done=0; row_count=0; flush counter=0; in_ready follows REQ-018 from reset state.
REQ-030 Reset asserted mid-tile SHALL discard all in-flight data, with no done pulse; the first cycle after release SHALL be IDLE.

Verification
REQ-031 N=4; 4 beats in_x=in_w={1.0,2.0,3.0,4.0}*beat# (beat 4 in_last), stall=0 -> lane k first nonzero k+1 cycles after beat 1; done exactly 4 flush advances after beat 4; row_count=4.
REQ-032 Same stream with stall=1 for 3 cycles mid-LOAD -> outputs/row_count frozen, in_ready=0, identical output sequence shifted 3 cycles.
REQ-033 in_valid gap of 2 cycles in LOAD -> two all-zero rows appear in skewed order on every lane; done timing extends by 2.
REQ-034 Single beat with in_last=1 from IDLE -> IDLE->FLUSH directly; lane 3 shows the value at cycle 4; done one cycle after the 4th flush advance.
REQ-035 n_rst pulsed low during FLUSH -> outputs 0 immediately (asynchronous), no done, next tile starts clean with row_count=0.
REQ-036 Stall asserted on the DONE cycle -> done still pulses once, returns to IDLE; in_valid held during FLUSH is accepted only after IDLE.
